// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target with byte-wide receive/transmit ports.
// Optional build macro I2C_SLAVE_STRETCH_EN: when defined, the block holds SCL
// low at the start of a read byte until tx_valid arrives instead of sending 8'hFF.
//
// Byte handshakes:
//   rx side: rx_valid is a one-clk pulse; rx_data holds the new byte from that
//            clk onward (no backpressure, every received byte is ACKed).
//   tx side: tx_valid=1 means tx_data holds a byte; tx_ready pulses for one clk
//            in the cycle the block takes tx_data into its shift register.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [3:0] state,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX        = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX        = 4'd5,
    ST_TX_ACK    = 4'd6,
    ST_WAIT_STOP = 4'd7
  } state_e;

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       scl_oe_q, scl_oe_d;
  logic       tx_wait_q, tx_wait_d;
`endif

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in, tx_byte;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & ~sda_prev_q & sda_sync_q;
  assign byte_in   = {shift_q[6:0], sda_sync_q};
  assign tx_byte   = tx_valid ? tx_data : 8'hFF;

  // Next-state and datapath; START/STOP override any SCL edge in the same clk.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
    scl_oe_d   = scl_oe_q;
    tx_wait_d  = tx_wait_q;
`endif
    if (start_det || stop_det) begin
      state_d   = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oe_d  = 1'b0;
      tx_wait_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_d = byte_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_RX) begin
                rx_data_d  = byte_in;
                rx_valid_d = 1'b1;
                state_d    = ST_RX_ACK;
              end else if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // First SCL fall drives ACK, second fall ends it. shift_q[0] is R/W.
        ST_ADDR_ACK, ST_RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ST_ADDR_ACK && shift_q[0]) begin
              // Read: SCL is already low, so bit 7 goes onto SDA right away.
              state_d = ST_TX;
`ifdef I2C_SLAVE_STRETCH_EN
              if (!tx_valid) begin
                sda_oe_d  = 1'b0;
                scl_oe_d  = 1'b1;
                tx_wait_d = 1'b1;
                bit_cnt_d = 4'd0;
              end else
`endif
              begin
                shift_d    = {tx_byte[6:0], 1'b0};
                sda_oe_d   = ~tx_byte[7];
                bit_cnt_d  = 4'd1;
                tx_ready_d = tx_valid;
              end
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX;
            end
          end
        end
        ST_TX: begin
`ifdef I2C_SLAVE_STRETCH_EN
          if (tx_wait_q) begin
            if (tx_valid) begin
              tx_wait_d  = 1'b0;
              tx_ready_d = 1'b1;
              scl_oe_d   = 1'b0;
              if (scl_oe_q || scl_fall) begin
                shift_d   = {tx_data[6:0], 1'b0};
                sda_oe_d  = ~tx_data[7];
                bit_cnt_d = 4'd1;
              end else begin
                shift_d = tx_data;
              end
            end else if (scl_fall) begin
              scl_oe_d = 1'b1;
            end
          end else
`endif
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // Master ACK (SDA low) starts another byte; NACK ends the read.
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_sync_q) begin
              state_d   = ST_TX;
              bit_cnt_d = 4'd0;
`ifdef I2C_SLAVE_STRETCH_EN
              if (!tx_valid) begin
                tx_wait_d = 1'b1;
              end else
`endif
              begin
                shift_d    = tx_byte;
                tx_ready_d = tx_valid;
              end
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oe_q   <= 1'b0;
      tx_wait_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oe_q   <= scl_oe_d;
      tx_wait_q  <= tx_wait_d;
`endif
    end
  end

`ifdef I2C_SLAVE_STRETCH_EN
  assign scl_oe = scl_oe_q;
`else
  assign scl_oe = 1'b0;
`endif
  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign state    = state_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master against i2c_slave on an open-drain bus.
// Expected ACKs, received bytes and returned bytes come from a transaction-level
// model: address match decides ACK, written bytes queue into exp_q, read bytes
// are tx_data when tx_valid else 8'hFF.
module tb_i2c_slave;

  localparam int         Q    = 10;      // quarter SCL period in clk cycles
  localparam logic [6:0] ADDR = 7'h50;

  // Clock/reset and bus
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_line, sda_line;
  logic       sda_oe, scl_oe, rx_valid, tx_ready, busy;
  logic [7:0] rx_data, tx_data;
  logic       tx_valid;
  logic [3:0] state;

  always #5 clk = ~clk;

  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_line), .sda_in(sda_line),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .state(state), .busy(busy)
  );

  // Scoreboard
  int         n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  int         rx_cnt = 0, tx_rdy_cnt = 0, sda_oe_cyc = 0, scl_oe_cyc = 0;
  logic       idle_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() > 0) check_eq("rx_data", rx_data, exp_q.pop_front());
        else check_eq("rx_unexpected", exp_q.size(), 1);
      end
      if (tx_ready) tx_rdy_cnt++;
      if (sda_oe) sda_oe_cyc++;
      if (scl_oe) scl_oe_cyc++;
      if (state == 4'd0) idle_seen = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    for (int i = 0; i < 3000 && !scl_line; i++) @(negedge clk);
    if (!scl_line) check_eq("scl_release_timeout", scl_line, 1);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_clk(Q);
    s = sda_line;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~m_ack, s);
  endtask

  // Stimulus
  logic       ack, s;
  logic [7:0] rb, d, exp_b;
  logic [6:0] a;
  logic       rw, v, match;
  int         nb, c0, c1;

  initial begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    wait_clk(4);
    check_eq("rst_state", state, 0);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_scl_oe", scl_oe, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(5);

    // Write: START, 0xA0, 0x3C, STOP
    c0 = rx_cnt;
    i2c_start();
    check_eq("wr_busy", busy, 1);
    send_byte(8'hA0, ack);
    check_eq("wr_addr_ack", ack, 1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, ack);
    check_eq("wr_data_ack", ack, 1);
    check_eq("wr_rx_count", rx_cnt - c0, 1);
    i2c_stop();
    check_eq("wr_idle", state, 0);
    check_eq("wr_rx_data_hold", rx_data, 8'h3C);

    // Address mismatch: START, 0xB0
    c0 = rx_cnt;
    c1 = sda_oe_cyc;
    i2c_start();
    send_byte(8'hB0, ack);
    check_eq("mm_no_ack", ack, 0);
    check_eq("mm_sda_oe_cycles", sda_oe_cyc - c1, 0);
    check_eq("mm_wait_stop", state, 7);
    send_byte(8'h55, ack);
    check_eq("mm_stay_wait_stop", state, 7);
    check_eq("mm_no_rx", rx_cnt - c0, 0);
    i2c_stop();
    check_eq("mm_idle", state, 0);

    // Read: 0x96 twice, master ACK then NACK
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    c0 = tx_rdy_cnt;
    i2c_start();
    send_byte(8'hA1, ack);
    check_eq("rd_addr_ack", ack, 1);
    check_eq("rd_state_tx", state, 5);
    recv_byte(1'b1, rb);
    check_eq("rd_byte0", rb, 8'h96);
    recv_byte(1'b0, rb);
    check_eq("rd_byte1", rb, 8'h96);
    check_eq("rd_tx_ready_count", tx_rdy_cnt - c0, 2);
    check_eq("rd_wait_stop", state, 7);
    i2c_stop();
    check_eq("rd_idle", state, 0);

    // Repeated START: write 0xA0 0x01, then START 0xA1
    i2c_start();
    idle_seen = 1'b0;
    send_byte(8'hA0, ack);
    check_eq("rs_addr_ack", ack, 1);
    exp_q.push_back(8'h01);
    send_byte(8'h01, ack);
    check_eq("rs_data_ack", ack, 1);
    i2c_start();
    check_eq("rs_state_addr", state, 1);
    check_eq("rs_no_idle", idle_seen, 0);
    tx_data = 8'($urandom_range(0, 255));
    send_byte(8'hA1, ack);
    check_eq("rs_addr2_ack", ack, 1);
    check_eq("rs_state_tx", state, 5);
    recv_byte(1'b0, rb);
    check_eq("rs_read_byte", rb, tx_data);
    i2c_stop();

`ifdef I2C_SLAVE_STRETCH_EN
    // Stretch: read with tx_valid low for 50 clk
    tx_valid = 1'b0;
    c0 = tx_rdy_cnt;
    c1 = scl_oe_cyc;
    i2c_start();
    send_byte(8'hA1, ack);
    check_eq("st_addr_ack", ack, 1);
    fork
      begin
        wait_clk(50);
        check_eq("st_scl_held", scl_oe, 1);
        check_eq("st_no_early_ready", tx_rdy_cnt - c0, 0);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
      end
      recv_byte(1'b0, rb);
    join
    check_eq("st_byte", rb, 8'h5A);
    check_eq("st_tx_ready_count", tx_rdy_cnt - c0, 1);
    check_eq("st_hold_len_ok", ((scl_oe_cyc - c1) >= 50) && ((scl_oe_cyc - c1) <= 70), 1);
    check_eq("st_scl_released", scl_oe, 0);
    i2c_stop();
`else
    // No data available: slave returns 8'hFF and never stretches
    tx_valid = 1'b0;
    c0 = tx_rdy_cnt;
    c1 = scl_oe_cyc;
    i2c_start();
    send_byte(8'hA1, ack);
    check_eq("ff_addr_ack", ack, 1);
    recv_byte(1'b1, rb);
    check_eq("ff_byte0", rb, 8'hFF);
    recv_byte(1'b0, rb);
    check_eq("ff_byte1", rb, 8'hFF);
    check_eq("ff_no_tx_ready", tx_rdy_cnt - c0, 0);
    check_eq("ff_no_stretch", scl_oe_cyc - c1, 0);
    i2c_stop();
`endif

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 12; t++) begin
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) < 6) a = ADDR;
      match = (a == ADDR);
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      d  = 8'($urandom_range(0, 255));
`ifdef I2C_SLAVE_STRETCH_EN
      v = 1'b1;
`else
      v = 1'($urandom_range(0, 1));
`endif
      tx_data  = d;
      tx_valid = v;
      c0 = tx_rdy_cnt;
      c1 = rx_cnt;
      i2c_start();
      send_byte({a, rw}, ack);
      check_eq("rnd_addr_ack", ack, match);
      if (!rw) begin
        for (int i = 0; i < nb; i++) begin
          d = 8'($urandom_range(0, 255));
          if (match) exp_q.push_back(d);
          send_byte(d, ack);
          check_eq("rnd_data_ack", ack, match);
        end
        check_eq("rnd_rx_count", rx_cnt - c1, match ? nb : 0);
      end else begin
        exp_b = (match && v) ? tx_data : 8'hFF;
        for (int i = 0; i < nb; i++) begin
          recv_byte(i < nb - 1, rb);
          check_eq("rnd_read_byte", rb, exp_b);
        end
        check_eq("rnd_tx_ready_count", tx_rdy_cnt - c0, (match && v) ? nb : 0);
      end
      i2c_stop();
      check_eq("rnd_idle", state, 0);
    end

    // Reset during RX bit 4
    tx_valid = 1'b0;
    i2c_start();
    send_byte(8'hA0, ack);
    check_eq("mr_addr_ack", ack, 1);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    sda_m = 1'b0;
    wait_clk(Q / 2);
    rst_n = 1'b0;
    wait_clk(3);
    check_eq("mr_state", state, 0);
    check_eq("mr_sda_oe", sda_oe, 0);
    check_eq("mr_scl_oe", scl_oe, 0);
    check_eq("mr_rx_data", rx_data, 0);
    check_eq("mr_rx_valid", rx_valid, 0);
    check_eq("mr_tx_ready", tx_ready, 0);
    check_eq("mr_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(5);
    c1 = rx_cnt;
    for (int i = 0; i < 5; i++) clock_bit(1'($urandom_range(0, 1)), s);
    clock_bit(1'b1, s);
    check_eq("mr_no_ack", s, 1);
    check_eq("mr_still_idle", state, 0);
    check_eq("mr_no_rx", rx_cnt - c1, 0);
    i2c_stop();

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, 7-bit address the block responds to.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port scl_in  input  1  raw SCL pin level.
REQ-005 SHALL have port sda_in  input  1  raw SDA pin level.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-007 SHALL have port scl_oe  output  1  1 = pull SCL low (clock stretch).
REQ-008 SHALL have port rx_data  output  8  last byte written by master, MSB first.
REQ-009 SHALL have port rx_valid  output  1  one-clk pulse, rx_data new.
REQ-010 SHALL have port tx_data  input  8  next byte to return to master.
REQ-011 SHALL have port tx_valid  input  1  tx_data holds a byte.
REQ-012 SHALL have port tx_ready  output  1  one-clk pulse, tx_data consumed.
REQ-013 SHALL have port state  output  4  current FSM state.
REQ-014 SHALL have port busy  output  1  1 in any state other than IDLE.

Function
REQ-015 SHALL pass scl_in and sda_in through 2-flop synchronizers; edge and START/STOP detection use synchronized values only.
REQ-016 SHALL define START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-017 SHALL use states IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
REQ-018 SHALL enter ADDR on START from any state, including repeated START mid-transfer, and clear the bit counter.
REQ-019 SHALL enter IDLE on STOP from any state, releasing sda_oe and scl_oe in the same clock.
REQ-020 SHALL sample SDA on each SCL rising edge in ADDR/RX, shifting MSB first; 8 bits complete a byte.
REQ-021 SHALL go ADDR -> ADDR_ACK when the 7 address bits equal SLAVE_ADDR; on mismatch, go to WAIT_STOP with sda_oe never asserted.
REQ-022 SHALL drive sda_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge in ADDR_ACK and RX_ACK.
REQ-023 SHALL exit ADDR_ACK at that falling edge to RX when R/W=0 and to TX when R/W=1.
REQ-024 SHALL update rx_data and pulse rx_valid at the 8th SCL rising edge in RX, then go to RX_ACK, then back to RX; every received byte is ACKed.
REQ-025 SHALL, on entry to TX, load tx_data into the shift register, pulse tx_ready only when tx_valid=1, and load 8'hFF without a tx_ready pulse when tx_valid=0.
REQ-026 SHALL update SDA only on SCL falling edges in TX: sda_oe = ~bit, MSB first, released after bit 0.
REQ-027 SHALL sample master ACK at the SCL rising edge in TX_ACK: SDA low -> TX (next byte), SDA high (NACK) -> WAIT_STOP.
REQ-028 SHALL leave WAIT_STOP only on STOP (to IDLE) or START (to ADDR).
REQ-029 SHALL, for an SCL edge coincident with a START/STOP detect, give priority to START/STOP.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, sda_oe=0, scl_oe=0, rx_data=8'h00, rx_valid=0, tx_ready=0, busy=0, synchronizers to 1, and counters to 0.
REQ-031 SHALL, when reset is released mid-transfer, stay in IDLE until a new START.

Configuration
REQ-032 SHALL use macro I2C_SLAVE_STRETCH_EN; when defined, on entry to TX with tx_valid=0, hold scl_oe=1 after the SCL falling edge until tx_valid=1, then load tx_data, pulse tx_ready and release scl_oe the next clk.
REQ-033 SHALL, without I2C_SLAVE_STRETCH_EN, tie scl_oe to 0 and apply the REQ-025 8'hFF behaviour.

Verification
REQ-034 SHALL cover write: START, 0xA0, 0x3C, STOP -> ACK on both bytes, one rx_valid with rx_data=0x3C, state=IDLE after STOP.
REQ-035 SHALL cover address mismatch: START, 0xB0 -> no ACK (sda_oe stays 0), state=WAIT_STOP, no rx_valid.
REQ-036 SHALL cover read: START, 0xA1, tx_data=0x96 valid, master ACK then NACK -> SDA bits 1001_0110, two tx_ready pulses, WAIT_STOP after NACK.
REQ-037 SHALL cover repeated START: write 0xA0, 0x01, then START, 0xA1 -> ADDR re-entered without IDLE, then TX.
REQ-038 SHALL cover reset mid-transfer: rst_n low during RX bit 4 -> all outputs at reset values, SDA released.
REQ-039 SHALL cover stretching with macro defined: read with tx_valid=0 for 50 clk -> scl_oe=1 for that time, then byte sent correctly.
